// File: rtl/uart_hamming_receiver_if.sv
// rtl/uart_hamming_receiver_if.sv - serial input and decoded-result bundle for the Hamming UART receiver
interface uart_hamming_receiver_if;
  logic       rx;
  logic       ena;
  logic [3:0] data_out;
  logic       data_valid;
  logic       corrected;
  logic [2:0] syndrome;
  logic       pad_err;
  logic       frame_err;
  logic       busy;

  // Drives the line and enable, observes the decoded results
  modport master (
    output rx,
    output ena,
    input  data_out,
    input  data_valid,
    input  corrected,
    input  syndrome,
    input  pad_err,
    input  frame_err,
    input  busy
  );

  // The receiver itself
  modport slave (
    input  rx,
    input  ena,
    output data_out,
    output data_valid,
    output corrected,
    output syndrome,
    output pad_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_hamming_receiver.sv
// rtl/uart_hamming_receiver.sv - 8N1 UART receiver with Hamming(7,4) single-error correction
module uart_hamming_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  uart_hamming_receiver_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          sync1;
  logic          rs;

  logic [3:0]    data_q;
  logic          valid_q;
  logic          corr_q;
  logic [2:0]    syn_q;
  logic          pad_q;
  logic          ferr_q;
  logic          busy_q;

  logic [6:0]    cw;
  logic [6:0]    fixed;
  logic [2:0]    syn;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rs    <= sync1;
    end
  end

  // Syndrome and single-bit correction on the captured byte; the syndrome names the bad bit position
  always_comb begin
    cw    = shreg[6:0];
    syn   = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
             cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
             cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    fixed = cw;
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~cw[syn - 3'd1];
    end
  end

  // Frame FSM: mid-bit sampling, stop check, decode register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      shreg   <= 8'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      corr_q  <= 1'b0;
      syn_q   <= 3'd0;
      pad_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ena && !rs) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rs) begin
              state <= DATA;
              idx   <= 3'd0;
            end else begin
              // Glitch shorter than half a bit: drop it silently
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rs;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rs) begin
              data_q  <= {fixed[6], fixed[5], fixed[4], fixed[2]};
              syn_q   <= syn;
              corr_q  <= (syn != 3'd0);
              pad_q   <= shreg[7];
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Bad stop: report once, keep held outputs, wait out any break
              ferr_q <= 1'b1;
              state  <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.corrected  = corr_q;
  assign bus.syndrome   = syn_q;
  assign bus.pad_err    = pad_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule
